// File: rtl/mem_stage_pkg.sv
// Shared state encoding, access-size constants and lane-mask helpers for the MEM stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;
  localparam int         F3_UNS_BIT = 2;

  // Byte-lane mask of an access of the given size, anchored at lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    size_mask = 8'h01;
      SZ_H:    size_mask = 8'h03;
      SZ_W:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  // Offset bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    align_mask = 3'b000;
      SZ_H:    align_mask = 3'b001;
      SZ_W:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Moves the addressed bytes of a memory word down to bit 0 and applies size and extension.
module mem_load_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  rdata_i,
  input  logic [OFF_W-1:0] off_i,
  input  logic [2:0]       funct3_i,
  output logic [XLEN-1:0]  data_o
);

  logic        [XLEN-1:0] shifted;
  logic signed [7:0]      b_s;
  logic signed [15:0]     h_s;
  logic signed [31:0]     w_s;

  assign shifted = rdata_i >> {off_i, 3'b000};
  assign b_s     = shifted[7:0];
  assign h_s     = shifted[15:0];
  assign w_s     = shifted[31:0];

  always_comb begin
    data_o = shifted;
    case (funct3_i[1:0])
      SZ_B: begin
        if (funct3_i[F3_UNS_BIT]) data_o = XLEN'(shifted[7:0]);
        else                      data_o = XLEN'(b_s);
      end
      SZ_H: begin
        if (funct3_i[F3_UNS_BIT]) data_o = XLEN'(shifted[15:0]);
        else                      data_o = XLEN'(h_s);
      end
      SZ_W: begin
        if (funct3_i[F3_UNS_BIT]) data_o = XLEN'(shifted[31:0]);
        else                      data_o = XLEN'(w_s);
      end
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: holds one instruction from EX, runs its memory access
// through a valid/ready request and response channel, and hands the result to WB.
module mem_stage_pipe
  import mem_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int RF_AW  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                EX_to_MEM_Valid,
  output logic                MEM_Allow_in,
  input  logic [XLEN-1:0]     ex_rs2_data,
  input  logic [XLEN-1:0]     ex_result,
  input  logic [2:0]          ex_funct3,
  input  logic                ex_load,
  input  logic                ex_store,
  input  logic                ex_wb_wen,
  input  logic [RF_AW-1:0]    ex_rf_waddr,
  input  logic [ADDR_W-1:0]   ex_pc,
  output logic                Mem_req_valid,
  input  logic                Mem_req_ready,
  output logic [ADDR_W-1:0]   Mem_addr,
  output logic                Mem_wen,
  output logic [XLEN/8-1:0]   Mem_wstrb,
  output logic [XLEN-1:0]     Mem_wdata,
  input  logic [XLEN-1:0]     Read_data,
  input  logic                Read_data_Valid,
  output logic                Read_data_Ready,
  input  logic                WB_Allow_in,
  output logic                MEM_to_WB_Valid,
  output logic                wb_wen,
  output logic [RF_AW-1:0]    wb_rf_waddr,
  output logic [XLEN-1:0]     wb_data,
  output logic [ADDR_W-1:0]   wb_pc,
  output logic                wb_misalign,
  output logic                rdw_wen,
  output logic                rdw_ready,
  output logic [RF_AW-1:0]    rdw_waddr,
  output logic [XLEN-1:0]     rdw_data,
  output logic                Mem_Feedback
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  mem_state_e        state_q, state_d;
  logic              valid_q, valid_d;

  logic [XLEN-1:0]   rs2_q, result_q, ldata_q, ldata_al;
  logic [2:0]        funct3_q;
  logic              load_q, store_q, wen_q, misal_q;
  logic [RF_AW-1:0]  waddr_q;
  logic [ADDR_W-1:0] pc_q;

  logic              accept, ex_misal, ex_go_req;
  logic [OFF_W-1:0]  ex_off, off_q;
  logic [1:0]        sz_q;

  // EX side: acceptance and alignment check of the offered instruction
  assign ex_off    = ex_result[OFF_W-1:0];
  assign ex_misal  = (ex_load || ex_store) &&
                     (((ex_funct3[1:0] == SZ_D) && (XLEN == 32)) ||
                      (|(3'(ex_off) & align_mask(ex_funct3[1:0]))));
  assign ex_go_req = (ex_load || ex_store) && !ex_misal;

  assign MEM_Allow_in = ((state_q == IDLE) && !valid_q) || (MEM_to_WB_Valid && WB_Allow_in);
  assign Mem_Feedback = MEM_Allow_in;
  assign accept       = EX_to_MEM_Valid && MEM_Allow_in;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = ex_go_req ? REQ : DONE;
        valid_d = 1'b1;
      end
      REQ:  if (Mem_req_ready)   state_d = store_q ? DONE : RESP;
      RESP: if (Read_data_Valid) state_d = DONE;
      DONE: if (WB_Allow_in) begin
        if (accept) begin
          state_d = ex_go_req ? REQ : DONE;
        end else begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  // Stage registers: datapath only, loaded on acceptance and on the load response
  always_ff @(posedge clk) begin
    if (accept) begin
      rs2_q    <= ex_rs2_data;
      result_q <= ex_result;
      funct3_q <= ex_funct3;
      load_q   <= ex_load;
      store_q  <= ex_store;
      wen_q    <= ex_wb_wen;
      waddr_q  <= ex_rf_waddr;
      pc_q     <= ex_pc;
      misal_q  <= ex_misal;
    end
    if ((state_q == RESP) && Read_data_Valid) ldata_q <= ldata_al;
  end

  // Memory request: lane strobes and replicated store data
  assign sz_q  = funct3_q[1:0];
  assign off_q = result_q[OFF_W-1:0];

  assign Mem_req_valid   = (state_q == REQ);
  assign Mem_addr        = ADDR_W'(result_q) & ~ADDR_W'(STRB_W - 1);
  assign Mem_wen         = store_q;
  assign Mem_wstrb       = STRB_W'(size_mask(sz_q)) << off_q;
  assign Read_data_Ready = rst || (state_q == RESP);

  always_comb begin
    Mem_wdata = rs2_q;
    case (sz_q)
      SZ_B:    Mem_wdata = {STRB_W{rs2_q[7:0]}};
      SZ_H:    Mem_wdata = {(STRB_W / 2){rs2_q[15:0]}};
      SZ_W:    Mem_wdata = {(STRB_W / 4){rs2_q[31:0]}};
      default: Mem_wdata = rs2_q;
    endcase
  end

  mem_load_align #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_load_align (
    .rdata_i  (Read_data),
    .off_i    (off_q),
    .funct3_i (funct3_q),
    .data_o   (ldata_al)
  );

  // WB side and bypass
  assign MEM_to_WB_Valid = (state_q == DONE);
  assign wb_wen          = wen_q && !misal_q;
  assign wb_rf_waddr     = waddr_q;
  assign wb_data         = load_q ? ldata_q : result_q;
  assign wb_pc           = pc_q;
  assign wb_misalign     = misal_q && (state_q == DONE);

  assign rdw_wen   = wb_wen && valid_q;
  assign rdw_ready = (state_q == DONE);
  assign rdw_waddr = waddr_q;
  assign rdw_data  = wb_data;

endmodule

// File: doc/mem_stage_pipe.md
MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, address and PC width.
REQ-003 SHALL have parameter RF_AW, default 5, register-file address width.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, named as follows:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have the EX-side ports:
- EX_to_MEM_Valid  in  1  EX offers an instruction.
- MEM_Allow_in  out  1  stage accepts from EX.
- ex_rs2_data  in  XLEN  store data.
- ex_result  in  XLEN  ALU result or effective address.
- ex_funct3  in  3  access size and sign.
- ex_load, ex_store, ex_wb_wen  in  1 each  instruction class and write-back enable.
- ex_rf_waddr  in  RF_AW  destination register.
- ex_pc  in  ADDR_W  instruction PC.
REQ-006 SHALL have the memory request ports:
- Mem_req_valid  out  1  request valid.
- Mem_req_ready  in  1  memory accepts the request.
- Mem_addr  out  ADDR_W  address aligned to XLEN/8.
- Mem_wen  out  1  1 = store.
- Mem_wstrb  out  XLEN/8  byte-lane strobes.
- Mem_wdata  out  XLEN  lane-replicated store data.
REQ-007 SHALL have the memory response ports:
- Read_data  in  XLEN  load data.
- Read_data_Valid  in  1  response valid.
- Read_data_Ready  out  1  stage accepts the response.
REQ-008 SHALL have the WB-side ports:
- WB_Allow_in  in  1  WB accepts.
- MEM_to_WB_Valid  out  1  result offered to WB.
- wb_wen  out  1  write-back enable.
- wb_rf_waddr  out  RF_AW  destination register.
- wb_data  out  XLEN  write-back data.
- wb_pc  out  ADDR_W  instruction PC.
- wb_misalign  out  1  misaligned or illegal access.
REQ-009 SHALL have the bypass ports:
- rdw_wen  out  1  wb_wen AND the stage is valid.
- rdw_ready  out  1  rdw_data is final.
- rdw_waddr  out  RF_AW  destination register.
- rdw_data  out  XLEN  forwarded data.
- Mem_Feedback  out  1  equals MEM_Allow_in.

Function
REQ-010 SHALL implement the FSM states IDLE, REQ, RESP, DONE.
REQ-011 SHALL assert MEM_Allow_in = (state==IDLE && !valid) || (MEM_to_WB_Valid && WB_Allow_in).
REQ-012 SHALL register all EX fields on EX_to_MEM_Valid && MEM_Allow_in.
REQ-013 SHALL enter REQ on that acceptance if the instruction is a load or store and is aligned; otherwise it SHALL enter DONE.
REQ-014 SHALL hold Mem_req_valid high in REQ with stable Mem_addr, Mem_wen, Mem_wstrb and Mem_wdata until Mem_req_ready.
REQ-015 SHALL move a store from REQ to DONE, and a load from REQ to RESP, on the cycle of Mem_req_valid && Mem_req_ready.
REQ-016 SHALL drive Read_data_Ready = 1 in RESP, independent of WB_Allow_in.
REQ-017 SHALL move to DONE on Read_data_Valid in RESP and capture the aligned, extended load data in a result register.
REQ-018 SHALL assert MEM_to_WB_Valid only in DONE.
REQ-019 SHALL leave DONE on WB_Allow_in, going to REQ or DONE if EX offers a new instruction in the same cycle (back-to-back), else to IDLE.
REQ-020 SHALL decode size from funct3[1:0] as 00 byte, 01 half, 10 word, 11 double; double is legal only when XLEN=64.
REQ-021 SHALL zero-extend loads when funct3[2]=1 and sign-extend them otherwise.
REQ-022 SHALL compute the lane offset as ex_result[log2(XLEN/8)-1:0].
REQ-023 SHALL flag misalignment when the offset is not a multiple of the size.
REQ-024 SHALL treat funct3[1:0]=11 with XLEN=32 as misaligned.
REQ-025 SHALL, on misalignment, issue no memory request, force wb_wen=0 and rdw_wen=0, and set wb_misalign=1.
REQ-026 SHALL form Mem_wstrb as the size mask shifted left by the offset.
REQ-027 SHALL form Mem_wdata as the low size bytes of rs2 replicated across all lanes.
REQ-028 SHALL set wb_data to the ALU result for non-load instructions and to the captured load data for loads.
REQ-029 SHALL set rdw_ready = (state==DONE); rdw_data SHALL equal wb_data.
REQ-030 SHALL ignore a Read_data_Valid that arrives outside RESP; this is not an error.

Reset
REQ-031 SHALL, on rst assertion at any time including mid-request, force the state to IDLE and valid to 0 asynchronously.
REQ-032 SHALL hold Mem_req_valid, MEM_to_WB_Valid, rdw_wen, rdw_ready and wb_misalign at 0 during reset.
REQ-033 SHALL drive Read_data_Ready = 1 while rst is high, to drain stale responses.
REQ-034 SHALL NOT reset the datapath registers; their contents are don't-care until first capture.

Structure
REQ-035 SHALL place the state enum, funct3 size and sign constants, and the size-mask function in package mem_stage_pkg.
REQ-036 SHALL contain one combinational sub-module, mem_load_align, which shifts Read_data by the offset and applies size and extension.

Verification
REQ-037 XLEN=32: LB at addr 0x1003, Read_data=0x80FF_FFFF -> wb_data=0xFFFF_FF80, MEM_to_WB_Valid one cycle after the response.
REQ-038 XLEN=32: SH at addr 0x2002 with rs2=0x1234_ABCD -> Mem_wstrb=1100, Mem_wdata=0xABCD_ABCD, Mem_addr=0x2000, no response awaited.
REQ-039 LW at addr 0x3001 -> no Mem_req_valid, wb_misalign=1, wb_wen=0 in DONE on the next cycle.
REQ-040 XLEN=64: LWU at addr 0x..4, Read_data=0xDEAD_BEEF_0000_0001 -> wb_data=0x0000_0000_DEAD_BEEF.
REQ-041 Load with Mem_req_ready held low 3 cycles, then the response delayed 2 cycles -> all outputs stable, MEM_Allow_in=0 throughout, one WB transfer.
REQ-042 rst pulsed while in RESP -> state IDLE immediately, Read_data_Ready=1 during reset, a later stray response produces no WB output.
